// File: rtl/unidad_riesgos_if.sv
// rtl/unidad_riesgos_if.sv - pipeline hazard-unit bundle: stage inputs and pipeline control outputs
interface unidad_riesgos_if;
    logic [4:0]  IdRs;
    logic [4:0]  IdRt;
    logic [4:0]  ExRt;
    logic        ExMemRead;
    logic        MemBranch;
    logic        MemZeroFlag;
    logic        MemAcceso;
    logic        MemListo;

    logic        PcWrite;
    logic        IfIdWrite;
    logic        IdExWrite;
    logic        ExMemWrite;
    logic        IfIdFlush;
    logic        IdExFlush;
    logic        ExMemFlush;
    logic        PcSrc;
    logic        MemReq;
    logic        Fallo;
    logic [1:0]  Estado;
    logic [15:0] StallCount;

    modport master (
        input  IdRs, IdRt, ExRt, ExMemRead, MemBranch, MemZeroFlag, MemAcceso, MemListo,
        output PcWrite, IfIdWrite, IdExWrite, ExMemWrite, IfIdFlush, IdExFlush, ExMemFlush,
        output PcSrc, MemReq, Fallo, Estado, StallCount
    );

    modport slave (
        output IdRs, IdRt, ExRt, ExMemRead, MemBranch, MemZeroFlag, MemAcceso, MemListo,
        input  PcWrite, IfIdWrite, IdExWrite, ExMemWrite, IfIdFlush, IdExFlush, ExMemFlush,
        input  PcSrc, MemReq, Fallo, Estado, StallCount
    );
endinterface

// File: rtl/unidad_riesgos.sv
// rtl/unidad_riesgos.sv - hazard unit: memory-wait stall with timeout, branch flush, load-use bubble
module unidad_riesgos (
    input  logic               clk,
    input  logic               rst_n,
    unidad_riesgos_if.master   bus
);
    typedef enum logic [1:0] {
        RUN       = 2'b00,
        MEM_WAIT  = 2'b01,
        FALLO     = 2'b10,
        RESERVADO = 2'b11
    } estado_t;

    estado_t     estado, estadoSig;
    logic [3:0]  waitCnt, waitCntSig;
    logic [15:0] stallCount;

    logic branchTaken, loadUse, memEspera, evalRun;
    logic pcWrite, ifIdWrite, idExWrite, exMemWrite;
    logic ifIdFlush, idExFlush, exMemFlush;
    logic pcSrc, memReq, fallo;

    assign branchTaken = bus.MemBranch & bus.MemZeroFlag;
    assign loadUse     = bus.ExMemRead && (bus.ExRt != 5'd0) &&
                         ((bus.ExRt == bus.IdRs) || (bus.ExRt == bus.IdRt));

    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        idExWrite  = 1'b1;
        exMemWrite = 1'b1;
        ifIdFlush  = 1'b0;
        idExFlush  = 1'b0;
        exMemFlush = 1'b0;
        pcSrc      = 1'b0;
        memReq     = 1'b0;
        fallo      = 1'b0;
        estadoSig  = RUN;
        waitCntSig = 4'd0;
        evalRun    = 1'b0;
        memEspera  = 1'b0;

        case (estado)
            MEM_WAIT: begin
                memReq = 1'b1;
                if (!bus.MemListo) begin
                    pcWrite    = 1'b0;
                    ifIdWrite  = 1'b0;
                    idExWrite  = 1'b0;
                    exMemWrite = 1'b0;
                    if (waitCnt == 4'd15) begin
                        estadoSig = FALLO;
                    end else begin
                        estadoSig  = MEM_WAIT;
                        waitCntSig = waitCnt + 4'd1;
                    end
                end else begin
                    // completion cycle: branch/load-use still resolve normally
                    evalRun = 1'b1;
                end
            end
            FALLO: begin
                pcWrite    = 1'b0;
                ifIdWrite  = 1'b0;
                idExWrite  = 1'b0;
                exMemWrite = 1'b0;
                fallo      = 1'b1;
                estadoSig  = FALLO;
            end
            default: begin
                evalRun   = 1'b1;
                memEspera = bus.MemAcceso & ~bus.MemListo;
                memReq    = bus.MemAcceso;
            end
        endcase

        if (evalRun) begin
            if (memEspera) begin
                pcWrite    = 1'b0;
                ifIdWrite  = 1'b0;
                idExWrite  = 1'b0;
                exMemWrite = 1'b0;
                memReq     = 1'b1;
                // the unused encoding only ever recovers to RUN
                estadoSig  = (estado == RUN) ? MEM_WAIT : RUN;
            end else if (branchTaken) begin
                pcSrc      = 1'b1;
                ifIdFlush  = 1'b1;
                idExFlush  = 1'b1;
                exMemFlush = 1'b1;
            end else if (loadUse) begin
                pcWrite    = 1'b0;
                ifIdWrite  = 1'b0;
                idExFlush  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado     <= RUN;
            waitCnt    <= 4'd0;
            stallCount <= 16'd0;
        end else begin
            estado  <= estadoSig;
            waitCnt <= waitCntSig;
            if (!pcWrite && (stallCount != 16'hFFFF)) begin
                stallCount <= stallCount + 16'd1;
            end
        end
    end

    // reset holds every control low, independent of the clock
    assign bus.PcWrite    = rst_n & pcWrite;
    assign bus.IfIdWrite  = rst_n & ifIdWrite;
    assign bus.IdExWrite  = rst_n & idExWrite;
    assign bus.ExMemWrite = rst_n & exMemWrite;
    assign bus.IfIdFlush  = rst_n & ifIdFlush;
    assign bus.IdExFlush  = rst_n & idExFlush;
    assign bus.ExMemFlush = rst_n & exMemFlush;
    assign bus.PcSrc      = rst_n & pcSrc;
    assign bus.MemReq     = rst_n & memReq;
    assign bus.Fallo      = rst_n & fallo;
    assign bus.Estado     = rst_n ? estado : 2'b00;
    assign bus.StallCount = stallCount;
endmodule
